// File: rtl/fifo_rd_pack_16to32.sv
`timescale 1ns/1ps
// fifo_rd_pack_16to32
//   Pulls 16-bit halves from the read side of an async FIFO and packs
//   consecutive pairs into 32-bit beats on a valid/ready output.
//
//   Optional build macro: PACK_LAST_EN
//     defined   -> 16-bit beat counter, m_last marks beat PKT_WORDS-1 of
//                  each packet (counter wraps after it)
//     undefined -> no counter, m_last tied low
//
// Parameters
//   PKT_WORDS  beats per packet (1..65535), used only with PACK_LAST_EN
//   LOW_FIRST  1: first half read lands in m_data[15:0]
//              0: first half read lands in m_data[31:16]
//
// Ports
//   rd_clk         clock, all logic on its rising edge
//   rd_rst         asynchronous active-high reset
//   fifo_rd_en     read strobe to the FIFO (never asserted while empty)
//   fifo_rd_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   flush          drop any held half and any half returning now
//   m_data         packed output word
//   m_valid        m_data valid
//   m_ready        downstream accept
//   m_last         final beat of a packet
//   half_pending   one half held, waiting for its partner
module fifo_rd_pack_16to32 #(
    parameter int unsigned PKT_WORDS = 256,
    parameter int unsigned LOW_FIRST = 1
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_rd_empty,
    input  logic        flush,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        half_pending
);

    // Halves held ahead of the output register: the half register
    // (oldest) and the skid half (its partner, while the output is busy).
    typedef enum logic [1:0] {
        HOLD_NONE = 2'd0,
        HOLD_ONE  = 2'd1,
        HOLD_PAIR = 2'd2
    } hold_t;

    hold_t       hold_q, hold_d;
    logic [15:0] half_q, half_d;
    logic [15:0] skid_q, skid_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        inflight_q;
    logic [1:0]  arm_q;

    logic        cap;
    logic        out_free;
    logic        load;
    logic [15:0] second_h;
    logic [2:0]  occ;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            hold_q     <= HOLD_NONE;
            half_q     <= '0;
            skid_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            inflight_q <= 1'b0;
            arm_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            half_q     <= half_d;
            skid_q     <= skid_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            inflight_q <= fifo_rd_en;
            arm_q      <= {arm_q[0], 1'b1};
        end
    end

    always_comb begin
        hold_d   = hold_q;
        half_d   = half_q;
        skid_d   = skid_q;
        data_d   = data_q;
        valid_d  = valid_q && !m_ready;
        second_h = fifo_rd_data;
        load     = 1'b0;

        // inflight_q is cleared by reset, so a read issued before reset
        // never produces a capture afterwards.
        cap      = inflight_q && !flush;
        out_free = !valid_q || m_ready;

        if (flush) begin
            hold_d = HOLD_NONE;
        end else begin
            case (hold_q)
                HOLD_NONE: begin
                    if (cap) begin
                        half_d = fifo_rd_data;
                        hold_d = HOLD_ONE;
                    end
                end
                HOLD_ONE: begin
                    if (cap) begin
                        if (out_free) begin
                            load   = 1'b1;
                            hold_d = HOLD_NONE;
                        end else begin
                            skid_d = fifo_rd_data;
                            hold_d = HOLD_PAIR;
                        end
                    end
                end
                HOLD_PAIR: begin
                    // A capture here is only possible when the output frees
                    // up this edge; the read throttle guarantees that.
                    if (out_free) begin
                        load     = 1'b1;
                        second_h = skid_q;
                        if (cap) begin
                            half_d = fifo_rd_data;
                            hold_d = HOLD_ONE;
                        end else begin
                            hold_d = HOLD_NONE;
                        end
                    end
                end
                default: hold_d = HOLD_NONE;
            endcase
        end

        if (load) begin
            valid_d = 1'b1;
            data_d  = (LOW_FIRST != 0) ? {second_h, half_q} : {half_q, second_h};
        end
    end

    // Halves the block is committed to: held, in the output register, and
    // returning from last cycle's read. Storage is four halves in total, so a
    // new read is issued only if it still fits without any handshake.
    always_comb begin
        occ = 3'(hold_q) + {1'b0, valid_q, 1'b0} + {2'b00, inflight_q};
    end

    assign fifo_rd_en   = arm_q[1] && !fifo_rd_empty && !flush && (occ < 3'd4);
    assign m_data       = data_q;
    assign m_valid      = valid_q;
    assign half_pending = (hold_q == HOLD_ONE);

`ifdef PACK_LAST_EN
    localparam logic [15:0] LAST_IDX = 16'(PKT_WORDS - 1);

    logic [15:0] beat_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            beat_q <= '0;
        end else if (valid_q && m_ready) begin
            beat_q <= (beat_q == LAST_IDX) ? '0 : beat_q + 16'd1;
        end
    end

    assign m_last = valid_q && (beat_q == LAST_IDX);
`else
    // No packet framing in this build; legal PKT_WORDS values make this 0.
    assign m_last = (PKT_WORDS == 0);
`endif

endmodule

// File: tb/tb_fifo_rd_pack_16to32.sv
`timescale 1ns/1ps
// Bench for fifo_rd_pack_16to32: two instances (LOW_FIRST=1 and 0) share
// one FIFO model; a queue-based reference predicts every beat.
module tb_fifo_rd_pack_16to32;

    localparam int unsigned PKT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_rd_empty = 1'b1;
    logic [15:0] fifo_rd_data = '0;

    logic        rd_en_lo, rd_en_hi;
    logic        valid_lo, valid_hi;
    logic        last_lo, last_hi;
    logic        hp_lo, hp_hi;
    logic [31:0] data_lo, data_hi;

    fifo_rd_pack_16to32 #(.PKT_WORDS(PKT), .LOW_FIRST(1)) u_lo (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_lo),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .flush(flush), .m_data(data_lo), .m_valid(valid_lo),
        .m_ready(m_ready), .m_last(last_lo), .half_pending(hp_lo)
    );

    fifo_rd_pack_16to32 #(.PKT_WORDS(PKT), .LOW_FIRST(0)) u_hi (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_hi),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .flush(flush), .m_data(data_hi), .m_valid(valid_hi),
        .m_ready(m_ready), .m_last(last_hi), .half_pending(hp_hi)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [15:0] q[$];
    logic [15:0] halves[$];
    logic [31:0] exp_lo[$], exp_hi[$];
    logic [31:0] got_lo[$], got_hi[$];
    bit          pend;
    bit          last_strobe;
    int unsigned beat_cnt, hs_total, lasts;
    int unsigned n_pass, n_chk;

    typedef struct packed {
        logic [3:0][15:0] h;
        int unsigned      nh;
        int unsigned      gap;
        logic [1:0][31:0] lo;
        logic [1:0][31:0] hi;
        int unsigned      nb;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    task automatic set_vec(input int idx, input logic [15:0] a, b, c, d,
                           input int unsigned nh, gap,
                           input logic [31:0] l0, l1, h0, h1, input int unsigned nb);
        vecs[idx].h[0] = a; vecs[idx].h[1] = b; vecs[idx].h[2] = c; vecs[idx].h[3] = d;
        vecs[idx].nh = nh; vecs[idx].gap = gap;
        vecs[idx].lo[0] = l0; vecs[idx].lo[1] = l1;
        vecs[idx].hi[0] = h0; vecs[idx].hi[1] = h1;
        vecs[idx].nb = nb;
    endtask

    task automatic model_reset();
        halves.delete();
        exp_lo.delete();
        exp_hi.delete();
        pend     = 1'b0;
        beat_cnt = 0;
    endtask

    task automatic check_outputs();
        logic exp_last;
        exp_last = 1'b0;
`ifdef PACK_LAST_EN
        exp_last = (exp_lo.size() != 0) && ((beat_cnt % PKT) == PKT - 1);
`endif
        chk("half_pending_lo", hp_lo, halves.size() == 1);
        chk("half_pending_hi", hp_hi, halves.size() == 1);
        chk("m_valid_lo", valid_lo, exp_lo.size() != 0);
        chk("m_valid_hi", valid_hi, exp_hi.size() != 0);
        if (exp_lo.size() != 0) begin
            chk("m_data_lo", data_lo, exp_lo[0]);
            chk("m_data_hi", data_hi, exp_hi[0]);
        end
        chk("m_last_lo", last_lo, exp_last);
        chk("m_last_hi", last_hi, exp_last);
        chk("storage_limit", (halves.size() + 2 * exp_lo.size() + pend) <= 4, 1);
    endtask

    // One clock: inputs change at the falling edge, the model follows the
    // rising edge, FIFO data appears just after the edge that read it.
    task automatic cycle(input bit rdy, input bit fl, input bit rs);
        bit          strobe, hs;
        logic [31:0] d_lo, d_hi;
        logic        l_lo;
        @(negedge clk);
        check_outputs();
        m_ready = rdy;
        flush = fl;
        rst = rs;
        fifo_rd_empty = (q.size() == 0);
        if (rs) model_reset();
        #1;
        chk("rd_en_lo_while_empty", rd_en_lo && fifo_rd_empty, 0);
        chk("rd_en_hi_while_empty", rd_en_hi && fifo_rd_empty, 0);
        strobe = rd_en_lo;
        last_strobe = strobe;
        hs = valid_lo && m_ready;
        d_lo = data_lo;
        d_hi = data_hi;
        l_lo = last_lo;
        @(posedge clk);
        #1;
        if (!rs) begin
            if (hs) begin
                got_lo.push_back(d_lo);
                got_hi.push_back(d_hi);
                if (l_lo) lasts++;
                hs_total++;
                beat_cnt++;
                if (exp_lo.size() != 0) begin
                    void'(exp_lo.pop_front());
                    void'(exp_hi.pop_front());
                end
            end
            if (fl) begin
                halves.delete();
            end else if (pend) begin
                halves.push_back(fifo_rd_data);
                if (halves.size() == 2) begin
                    exp_lo.push_back({halves[1], halves[0]});
                    exp_hi.push_back({halves[0], halves[1]});
                    halves.delete();
                end
            end
        end
        pend = strobe && !rs;
        if (strobe && q.size() != 0) fifo_rd_data = q.pop_front();
        else fifo_rd_data = 16'($urandom);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        q.delete();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        got_lo.delete();
        got_hi.delete();
        lasts = 0;
    endtask

    function automatic logic [31:0] first_of(input logic [31:0] g[$]);
        return (g.size() != 0) ? g[0] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int unsigned base, exp_lasts;

        set_vec(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4, 0,
                32'h2222_1111, 32'h4444_3333, 32'h1111_2222, 32'h3333_4444, 2);
        set_vec(1, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 2, 20,
                32'hBBBB_AAAA, 32'h0, 32'hAAAA_BBBB, 32'h0, 1);
        set_vec(2, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 4, 3,
                32'h5678_1234, 32'hDEF0_9ABC, 32'h1234_5678, 32'h9ABC_DEF0, 2);

        // Directed pairing vectors (both lane orders)
        for (int i = 0; i < 3; i++) begin
            do_reset();
            q.push_back(vecs[i].h[0]);
            if (vecs[i].gap != 0) begin
                run(int'(vecs[i].gap), 1'b1);
                chk("gap_half_pending", hp_lo, 1);
                chk("gap_no_valid", valid_lo, 0);
            end
            for (int j = 1; j < int'(vecs[i].nh); j++) q.push_back(vecs[i].h[j]);
            run(12, 1'b1);
            chk("vec_beat_count", got_lo.size(), vecs[i].nb);
            for (int j = 0; j < int'(vecs[i].nb) && j < got_lo.size(); j++) begin
                chk("vec_beat_lo", got_lo[j], vecs[i].lo[j]);
                chk("vec_beat_hi", got_hi[j], vecs[i].hi[j]);
            end
        end

        // Reset one cycle after a read: outputs cleared, returning half lost
        do_reset();
        q.push_back(16'h1357);
        cycle(1'b1, 1'b0, 1'b0);
        chk("pre_reset_read", last_strobe, 1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("rst_m_valid", valid_lo, 0);
        chk("rst_m_data", data_lo, 0);
        chk("rst_m_last", last_lo, 0);
        chk("rst_half_pending", hp_lo, 0);
        chk("rst_rd_en", rd_en_lo, 0);
        q.push_back(16'h2468);
        q.push_back(16'hACE0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("first_rd_en_after_reset", last_strobe, 0);
        run(10, 1'b1);
        chk("post_reset_beats", got_lo.size(), 1);
        chk("post_reset_beat_lo", first_of(got_lo), 32'hACE0_2468);
        chk("post_reset_beat_hi", first_of(got_hi), 32'h2468_ACE0);

        // Flush with one half held and a read returning in the flush cycle
        do_reset();
        q.push_back(16'h5555);
        run(3, 1'b1);
        chk("flush_pre_half", hp_lo, 1);
        q.push_back(16'h9999);
        cycle(1'b1, 1'b0, 1'b0);
        chk("flush_pre_read", last_strobe, 1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("flush_cleared", hp_lo, 0);
        q.push_back(16'h6666);
        q.push_back(16'h7777);
        run(8, 1'b1);
        chk("flush_beats", got_lo.size(), 1);
        chk("flush_beat_lo", first_of(got_lo), 32'h7777_6666);
        chk("flush_beat_hi", first_of(got_hi), 32'h6666_7777);

        // Packet framing: 10 beats of 4-beat packets
        do_reset();
        for (int i = 0; i < 20; i++) q.push_back(16'($urandom));
        base = hs_total;
        run(40, 1'b1);
        chk("framing_beats", hs_total - base, 10);
        exp_lasts = 0;
`ifdef PACK_LAST_EN
        exp_lasts = 2;
`endif
        chk("framing_last_count", lasts, exp_lasts);

        // Throughput, then a 5-cycle stall mid-stream
        do_reset();
        for (int i = 0; i < 200; i++) q.push_back(16'($urandom));
        run(10, 1'b1);
        base = hs_total;
        run(40, 1'b1);
        chk("throughput_40cyc", hs_total - base, 20);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("stall_rd_en_off", last_strobe, 0);
        run(30, 1'b1);

        // Random supply, backpressure and occasional flush
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bit rdy, fl;
            if (q.size() < 6 && $urandom_range(0, 2) != 0) q.push_back(16'($urandom));
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 39) == 0) && (exp_lo.size() <= 1);
            cycle(rdy, fl, 1'b0);
        end
        run(20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
